// File: rtl/jackpot_pkg.sv
// Shared encodings for the jackpot reaction game: FSM states, walk mode and bounce direction.
package jackpot_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StRun     = 2'd0;
  localparam state_t StWin     = 2'd1;
  localparam state_t StLockout = 2'd2;

  localparam logic ModeRotate = 1'b0;
  localparam logic ModeBounce = 1'b1;

  localparam logic DirDown = 1'b0;
  localparam logic DirUp   = 1'b1;

endpackage

// File: rtl/switch_sync.sv
// Two-flop synchroniser bank for the asynchronous board switches.
module switch_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             newCLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge newCLK or posedge RESET) begin
    if (RESET) begin
      meta_q <= '0;
      dout   <= '0;
    end else begin
      meta_q <= din;
      dout   <= meta_q;
    end
  end

endmodule

// File: rtl/jackpot_game.sv
// Reaction game: a single lit LED walks across the bank; matching it with the switches scores a win,
// shows a timed blink and then locks out until every switch is cleared.
module jackpot_game
  import jackpot_pkg::*;
#(
  parameter int unsigned N_LEDS    = 4,
  parameter int unsigned STEP_DIV  = 1,
  parameter int unsigned WIN_TICKS = 8,
  parameter int unsigned SCORE_W   = 8
) (
  input  logic               newCLK,
  input  logic               RESET,
  input  logic [N_LEDS-1:0]  SWITCHES,
  input  logic               MODE,
  output logic [N_LEDS-1:0]  LEDS,
  output logic               WIN,
  output logic [SCORE_W-1:0] SCORE
);

  localparam int unsigned CntW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned WinW = $clog2(WIN_TICKS + 1);
  localparam logic [CntW-1:0]   CntLast  = CntW'(STEP_DIV - 1);
  localparam logic [WinW-1:0]   WinLast  = WinW'(WIN_TICKS);
  localparam logic [N_LEDS-1:0] PosReset = {1'b1, {(N_LEDS - 1){1'b0}}};

  logic [N_LEDS-1:0]  sw_s;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               tick;
  state_t             state_q, state_d;
  logic [N_LEDS-1:0]  pos_q, pos_d, step_pos;
  logic               dir_q, dir_d, step_dir;
  logic [WinW-1:0]    win_cnt_q, win_cnt_d;
  logic [N_LEDS-1:0]  leds_q, leds_d;
  logic               win_q, win_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               match;

  switch_sync #(
    .WIDTH (N_LEDS)
  ) u_switch_sync (
    .newCLK (newCLK),
    .RESET  (RESET),
    .din    (SWITCHES),
    .dout   (sw_s)
  );

  // Free-running step prescaler.
  assign tick  = (cnt_q == CntLast);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // A one-hot exact compare: zero or multi-bit switch patterns can never match.
  assign match = (sw_s == pos_q);

  always_comb begin
    step_pos = pos_q;
    step_dir = dir_q;
    unique case (MODE)
      ModeRotate: step_pos = {pos_q[0], pos_q[N_LEDS-1:1]};
      ModeBounce: begin
        if (dir_q == DirDown) begin
          if (pos_q[0]) begin
            step_dir = DirUp;
            step_pos = pos_q << 1;
          end else begin
            step_pos = pos_q >> 1;
          end
        end else begin
          if (pos_q[N_LEDS-1]) begin
            step_dir = DirDown;
            step_pos = pos_q >> 1;
          end else begin
            step_pos = pos_q << 1;
          end
        end
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    win_cnt_d = win_cnt_q;
    leds_d    = leds_q;
    score_d   = score_q;
    case (state_q)
      StRun: begin
        // A match wins over a same-cycle tick, freezing pos where it was hit.
        if (match) begin
          state_d   = StWin;
          win_cnt_d = '0;
          leds_d    = '1;
          score_d   = (&score_q) ? score_q : score_q + 1'b1;
        end else if (tick) begin
          pos_d  = step_pos;
          dir_d  = step_dir;
          leds_d = step_pos;
        end else begin
          leds_d = pos_q;
        end
      end
      StWin: begin
        if (tick) begin
          win_cnt_d = win_cnt_q + 1'b1;
          if ((win_cnt_q + 1'b1) == WinLast) begin
            state_d = StLockout;
            leds_d  = pos_q;
          end else begin
            leds_d = ~leds_q;
          end
        end
      end
      StLockout: begin
        leds_d = pos_q;
        if (sw_s == '0) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StRun;
        leds_d  = pos_q;
      end
    endcase
  end

  assign win_d = (state_d == StWin);

  always_ff @(posedge newCLK or posedge RESET) begin
    if (RESET) begin
      cnt_q     <= '0;
      state_q   <= StRun;
      pos_q     <= PosReset;
      dir_q     <= DirDown;
      win_cnt_q <= '0;
      leds_q    <= PosReset;
      win_q     <= 1'b0;
      score_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      win_cnt_q <= win_cnt_d;
      leds_q    <= leds_d;
      win_q     <= win_d;
      score_q   <= score_d;
    end
  end

  assign LEDS  = leds_q;
  assign WIN   = win_q;
  assign SCORE = score_q;

endmodule

// File: tb/tb_jackpot_game.sv
// Directed bench for jackpot_game; a second instance with a 2-bit score checks saturation.
module tb_jackpot_game;

  typedef struct {
    string      tag;
    logic [3:0] leds;
    logic       win;
    logic [7:0] score;
    logic [1:0] score2;
  } exp_t;

  logic       newCLK = 1'b0;
  logic       RESET;
  logic       MODE;
  logic [3:0] SWITCHES;
  logic [3:0] LEDS, leds2;
  logic       WIN, win2;
  logic [7:0] SCORE;
  logic [1:0] score2;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  jackpot_game #(
    .N_LEDS    (4),
    .STEP_DIV  (2),
    .WIN_TICKS (4),
    .SCORE_W   (8)
  ) dut (
    .newCLK   (newCLK),
    .RESET    (RESET),
    .SWITCHES (SWITCHES),
    .MODE     (MODE),
    .LEDS     (LEDS),
    .WIN      (WIN),
    .SCORE    (SCORE)
  );

  jackpot_game #(
    .N_LEDS    (4),
    .STEP_DIV  (2),
    .WIN_TICKS (4),
    .SCORE_W   (2)
  ) dut2 (
    .newCLK   (newCLK),
    .RESET    (RESET),
    .SWITCHES (SWITCHES),
    .MODE     (MODE),
    .LEDS     (leds2),
    .WIN      (win2),
    .SCORE    (score2)
  );

  always #5 newCLK = ~newCLK;

  function automatic logic [3:0] rot_next(input logic [3:0] p);
    return {p[0], p[3:1]};
  endfunction

  task automatic push(input string tag, input logic [3:0] leds, input logic win,
                      input logic [7:0] score);
    exp_t e;
    e.tag    = tag;
    e.leds   = leds;
    e.win    = win;
    e.score  = score;
    e.score2 = (score > 8'd3) ? 2'd3 : score[1:0];
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [19:0] obs, want;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed no entry, required one");
      return;
    end
    e    = sb.pop_front();
    obs  = {LEDS, WIN, SCORE, leds2, win2, score2};
    want = {e.leds, e.win, e.score, e.leds, e.win, e.score2};
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed leds=%b win=%b score=%0d leds2=%b win2=%b score2=%0d, required leds=%b win=%b score=%0d score2=%0d",
             e.tag, LEDS, WIN, SCORE, leds2, win2, score2, e.leds, e.win, e.score, e.score2);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge newCLK);
  endtask

  logic [3:0] bnc [7] = '{4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
  logic [3:0] blink_leds [7] = '{4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0010};
  logic       blink_win  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [3:0] pos;
    logic [3:0] tgt;

    RESET    = 1'b0;
    SWITCHES = 4'b0000;
    MODE     = 1'b0;
    #1 RESET = 1'b1;
    push("reset", 4'b1000, 1'b0, 8'd0);
    #1 pop_check();
    @(negedge newCLK);
    RESET = 1'b0;

    // Rotate: each position holds for one edge then advances on the next.
    pos = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      push($sformatf("rot_hold%0d", i), pos, 1'b0, 8'd0);
      edges(1);
      pop_check();
      pos = rot_next(pos);
      push($sformatf("rot_step%0d", i), pos, 1'b0, 8'd0);
      edges(1);
      pop_check();
    end

    MODE = 1'b1;
    for (int i = 0; i < 7; i++) begin
      push($sformatf("bounce%0d", i), bnc[i], 1'b0, 8'd0);
      edges(2);
      pop_check();
    end

    // Walk reaches 0010 on the second edge; WIN follows on the third.
    SWITCHES = 4'b0010;
    push("win_sync1", 4'b0100, 1'b0, 8'd0);
    edges(1);
    pop_check();
    push("win_sync2", 4'b0010, 1'b0, 8'd0);
    edges(1);
    pop_check();
    push("win_enter", 4'b1111, 1'b1, 8'd1);
    edges(1);
    pop_check();
    for (int i = 0; i < 7; i++) begin
      push($sformatf("blink%0d", i), blink_leds[i], blink_win[i], 8'd1);
      edges(1);
      pop_check();
    end
    push("lockout_hold", 4'b0010, 1'b0, 8'd1);
    edges(4);
    pop_check();

    SWITCHES = 4'b0000;
    push("lockout_exit", 4'b0010, 1'b0, 8'd1);
    edges(3);
    pop_check();
    push("resume", 4'b0001, 1'b0, 8'd1);
    edges(1);
    pop_check();

    SWITCHES = 4'b0011;
    push("multi_nowin", 4'b0010, 1'b0, 8'd1);
    edges(3);
    pop_check();
    push("multi_walk", 4'b0100, 1'b0, 8'd1);
    edges(1);
    pop_check();

    SWITCHES = 4'b1000;
    push("win_second", 4'b1111, 1'b1, 8'd2);
    edges(3);
    pop_check();
    #2 RESET = 1'b1;
    push("async_reset", 4'b1000, 1'b0, 8'd0);
    #1 pop_check();
    SWITCHES = 4'b0000;
    MODE     = 1'b0;
    @(negedge newCLK);
    RESET = 1'b0;

    pos = 4'b1000;
    for (int i = 1; i <= 5; i++) begin
      tgt      = rot_next(pos);
      SWITCHES = tgt;
      push($sformatf("sat_win%0d", i), 4'b1111, 1'b1, 8'(i));
      edges(3);
      pop_check();
      push($sformatf("sat_lock%0d", i), tgt, 1'b0, 8'(i));
      edges(7);
      pop_check();
      SWITCHES = 4'b0000;
      pos      = rot_next(tgt);
      push($sformatf("sat_resume%0d", i), pos, 1'b0, 8'(i));
      edges(4);
      pop_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
